// File: rtl/otter_rf_pkg.sv
// otter_rf_pkg: shared types and default sizing for the OTTER register file.
//   rf_state_e - controller states: CLEAR (zero-fill sweep) and RUN (normal use)
//   DEF_*      - default data width, register count and read-port count
package otter_rf_pkg;

   typedef enum logic {
      CLEAR,
      RUN
   } rf_state_e;

   localparam int unsigned DEF_XLEN  = 32;
   localparam int unsigned DEF_NREGS = 32;
   localparam int unsigned DEF_NRD   = 2;

endpackage

// File: rtl/otter_regfile_bypass_if.sv
// otter_regfile_bypass_if: bundle between a pipeline and the register file.
//   rd_addr  - NRD packed read indices, port k at [k*AW +: AW]
//   rd_data  - NRD packed read values, port k at [k*XLEN +: XLEN]
//   rd_pend  - per-port flag: addressed register awaits a reserved write
//   wr_en/wr_addr/wr_data - write strobe, index, value
//   rsv_en/rsv_addr       - mark a register as pending
//   ready    - register file has finished its clear sweep
// The master modport is the pipeline side, slave is the register file.
interface otter_regfile_bypass_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned NREGS = 32,
   parameter int unsigned NRD   = 2
) ();
   localparam int unsigned AW = $clog2(NREGS);

   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_pend;
   logic                wr_en;
   logic [AW-1:0]       wr_addr;
   logic [XLEN-1:0]     wr_data;
   logic                rsv_en;
   logic [AW-1:0]       rsv_addr;
   logic                ready;

   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
      input  rd_data, rd_pend, ready
   );

   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
      output rd_data, rd_pend, ready
   );

endinterface

// File: rtl/otter_rf_scoreboard.sv
// otter_rf_scoreboard: pending bit per register.
//   i_clk               - clock
//   i_clr_en/i_clr_addr - clear-sweep: force one bit to 0 (highest priority)
//   i_set_en/i_set_addr - reserve: set one bit
//   i_wr_en/i_wr_addr   - write commit: clear one bit
//   o_pend              - current pending bits, bit 0 is always 0
// Enables arrive already qualified by the controller state and reset.
module otter_rf_scoreboard #(
   parameter int unsigned NREGS = 32,
   parameter int unsigned AW    = $clog2(NREGS)
) (
   input  logic             i_clk,
   input  logic             i_clr_en,
   input  logic [AW-1:0]    i_clr_addr,
   input  logic             i_set_en,
   input  logic [AW-1:0]    i_set_addr,
   input  logic             i_wr_en,
   input  logic [AW-1:0]    i_wr_addr,
   output logic [NREGS-1:0] o_pend
);

   logic [NREGS-1:0] r_pend;

   // Reserve beats write on the same register: the reserving instruction is a
   // newer producer than the one whose result is landing now.
   always_ff @(posedge i_clk) begin
      for (int i = 0; i < int'(NREGS); i++) begin
         if (i == 0) begin
            r_pend[i] <= 1'b0;
         end else if (i_clr_en && (i_clr_addr == AW'(i))) begin
            r_pend[i] <= 1'b0;
         end else if (i_set_en && (i_set_addr == AW'(i))) begin
            r_pend[i] <= 1'b1;
         end else if (i_wr_en && (i_wr_addr == AW'(i))) begin
            r_pend[i] <= 1'b0;
         end
      end
   end

   assign o_pend = r_pend;

endmodule

// File: rtl/otter_regfile_bypass.sv
// otter_regfile_bypass: multi-port register file with write-to-read bypass
// and a pending (scoreboard) bit per register.
//   i_clock - clock, all state changes on the rising edge
//   i_reset - synchronous active-high reset; restarts the clear sweep
//   io_bus  - slave side of otter_regfile_bypass_if (reads, write, reserve,
//             ready)
// After reset the block sweeps every register to zero, one per cycle, and
// only then raises ready. Register 0 is hard-wired to zero and never pends.
module otter_regfile_bypass
   import otter_rf_pkg::*;
#(
   parameter int unsigned XLEN  = DEF_XLEN,
   parameter int unsigned NREGS = DEF_NREGS,
   parameter int unsigned NRD   = DEF_NRD
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   otter_regfile_bypass_if.slave io_bus
);

   localparam int unsigned AW = $clog2(NREGS);

   rf_state_e        r_state;
   rf_state_e        w_state_d;
   logic [AW-1:0]    r_cnt;
   logic [AW-1:0]    w_cnt_d;
   logic [XLEN-1:0]  r_rf [NREGS];
   logic [NREGS-1:0] w_pend;
   logic [AW-1:0]    w_ra;
   logic             w_run;
   logic             w_clear;
   logic             w_wr_act;
   logic             w_rsv_act;

   assign w_run     = (r_state == RUN);
   // A reset cycle never commits anything, whatever state it lands in.
   assign w_clear   = (r_state == CLEAR) && !i_reset;
   assign w_wr_act  = w_run && !i_reset && io_bus.wr_en && (io_bus.wr_addr != '0);
   assign w_rsv_act = w_run && !i_reset && io_bus.rsv_en && (io_bus.rsv_addr != '0);

   // Controller state register
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state <= CLEAR;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_d;
         r_cnt   <= w_cnt_d;
      end
   end

   always_comb begin
      w_state_d = r_state;
      w_cnt_d   = r_cnt;
      case (r_state)
         CLEAR: begin
            w_cnt_d = r_cnt + AW'(1);
            if (r_cnt == AW'(NREGS - 1)) begin
               w_state_d = RUN;
               w_cnt_d   = '0;
            end
         end
         RUN:     w_state_d = RUN;
         default: w_state_d = CLEAR;
      endcase
   end

   // Storage: the sweep owns the array while clearing.
   always_ff @(posedge i_clock) begin
      if (w_clear) begin
         r_rf[r_cnt] <= '0;
      end else if (w_wr_act) begin
         r_rf[io_bus.wr_addr] <= io_bus.wr_data;
      end
   end

   otter_rf_scoreboard #(
      .NREGS (NREGS),
      .AW    (AW)
   ) u_scoreboard (
      .i_clk      (i_clock),
      .i_clr_en   (w_clear),
      .i_clr_addr (r_cnt),
      .i_set_en   (w_rsv_act),
      .i_set_addr (io_bus.rsv_addr),
      .i_wr_en    (w_wr_act),
      .i_wr_addr  (io_bus.wr_addr),
      .o_pend     (w_pend)
   );

   // Read ports: zero while clearing or for x0; a same-cycle write to the
   // addressed register is forwarded and counts as no longer pending.
   always_comb begin
      io_bus.rd_data = '0;
      io_bus.rd_pend = '0;
      w_ra           = '0;
      for (int k = 0; k < int'(NRD); k++) begin
         w_ra = io_bus.rd_addr[k*AW +: AW];
         if (w_run && (w_ra != '0)) begin
            if (w_wr_act && (io_bus.wr_addr == w_ra)) begin
               io_bus.rd_data[k*XLEN +: XLEN] = io_bus.wr_data;
            end else begin
               io_bus.rd_data[k*XLEN +: XLEN] = r_rf[w_ra];
               io_bus.rd_pend[k]              = w_pend[w_ra];
            end
         end
      end
   end

   assign io_bus.ready = w_run;

endmodule

// File: doc/otter_regfile_bypass.md
OTTER_REGFILE_BYPASS -- requirements
Module: otter_regfile_bypass

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the register data width.
REQ-002 Parameter NREGS, default 32, SHALL set the register count (power of two, >=2); AW = $clog2(NREGS).
REQ-003 Parameter NRD, default 2, SHALL set the number of independent read ports (1..4).
REQ-004 clock  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  in  1  SHALL be synchronous, active-high.
REQ-006 rd_addr  in  NRD*AW  SHALL carry the read register indices; port k occupies bits [k*AW +: AW].
REQ-007 rd_data  out  NRD*XLEN  SHALL carry the read values, packed like rd_addr.
REQ-008 rd_pend  out  NRD  SHALL flag, per port, that the addressed register awaits a reserved write.
REQ-009 wr_en  in  1  SHALL be the write strobe.
REQ-010 wr_addr  in  AW  SHALL be the write index.
REQ-011 wr_data  in  XLEN  SHALL be the write value.
REQ-012 rsv_en  in  1  SHALL request that a register be marked pending.
REQ-013 rsv_addr  in  AW  SHALL be the reserve index.
REQ-014 ready  out  1  SHALL be high only in state RUN.

Function
REQ-015 Block SHALL hold storage RF[NREGS] and pending bits PEND[NREGS]; register 0 SHALL always read 0, never pend, and ignore writes/reserves.
REQ-016 FSM SHALL have states CLEAR and RUN; reset SHALL force CLEAR with clear counter = 0.
REQ-017 In CLEAR, each cycle SHALL write 0 to RF[cnt], clear PEND[cnt], and increment cnt; at cnt = NREGS-1 the next state SHALL be RUN (ready high exactly NREGS cycles after reset deasserts).
REQ-018 In CLEAR, wr_en and rsv_en SHALL be ignored; rd_data SHALL be 0 and rd_pend 0 on every port.
REQ-019 In RUN, a write with wr_en=1, wr_addr!=0 SHALL commit RF[wr_addr]=wr_data and clear PEND[wr_addr] at the rising edge (0-cycle write latency, no negedge writes).
REQ-020 In RUN, reads SHALL be combinational: rd_data[k] = RF[rd_addr[k]], or 0 when rd_addr[k]=0.
REQ-021 Bypass: if wr_en=1, wr_addr=rd_addr[k]!=0 in RUN, rd_data[k] SHALL equal wr_data in the same cycle and rd_pend[k] SHALL be 0.
REQ-022 Otherwise rd_pend[k] SHALL equal PEND[rd_addr[k]].
REQ-023 rsv_en=1 with rsv_addr!=0 in RUN SHALL set PEND[rsv_addr] at the next edge; it SHALL not bypass to rd_pend in the same cycle.
REQ-024 Simultaneous write and reserve to the same address SHALL commit the data and leave PEND set (reserve wins: new producer).
REQ-025 Simultaneous write and reserve to different addresses SHALL both take effect.
REQ-026 All NRD ports SHALL operate independently; identical addresses on several ports SHALL return identical results.

Reset
REQ-027 reset asserted in any state, including mid-CLEAR, SHALL restart CLEAR at cnt=0 at the next edge; ready SHALL be 0 from that edge.
REQ-028 Reset values: state=CLEAR, cnt=0, ready=0, rd_data=0, rd_pend=0; RF/PEND contents are defined only after CLEAR completes.

Structure
REQ-029 Package otter_rf_pkg SHALL hold the state enum (CLEAR, RUN) and default XLEN/NREGS/NRD constants.
REQ-030 Pending-bit logic SHALL be one sub-module, otter_rf_scoreboard (PEND array, set/clear priority, clear sweep input); storage and bypass stay in the top.

Verification
REQ-031 Reset 1 cycle, then idle -> ready low for exactly 32 cycles, high on cycle 33; all reads return 0.
REQ-032 RUN: write x5=0xDEADBEEF while rd_addr[0]=5 -> rd_data[0]=0xDEADBEEF same cycle; next cycle with wr_en=0 still 0xDEADBEEF.
REQ-033 Write x0=0x1234, read port 1 addr 0 same and next cycle -> 0 both cycles, rd_pend[1]=0.
REQ-034 Reserve x7, next cycle read x7 -> rd_pend=1; write x7=0x55 -> rd_pend=0 same cycle, data 0x55; simultaneous write+reserve x7 -> next cycle rd_pend=1, data=new value.
REQ-035 Reserve x9, reassert reset at cnt=10 of CLEAR -> ready stays low 32 further cycles, then x9 reads 0 with rd_pend=0.
REQ-036 Parameter sweep NREGS=16, NRD=4, XLEN=64: all four ports read distinct registers concurrently with correct values; CLEAR lasts 16 cycles.
